dds_poly_eval: RTL and testbench

Second-order polynomial evaluator for the DDS datapath, directly downstream of the coefficient ROMs (A0, A1, A2 banks, one registered read cycle each). It accepts a 32-bit phase word and splits it into a segment index (ROM address) and a fractional offset. It drives the shared ROM address/enable, then evaluates y = A0 + x·(A1 + x·A2) by Horner's rule with one shared multiply-shift-add-saturate datapath, and presents a 32-bit signed sample with a valid pulse.

---
 rtl/dds_poly_pkg.sv | 20 ++
 rtl/dds_horner_mac.sv | 38 +++
 rtl/dds_poly_eval.sv | 116 +++++++++++
 tb/tb_dds_poly_eval.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dds_poly_pkg.sv
// Shared definitions for the DDS polynomial evaluator: default widths,
// FSM state encoding and the saturation bounds used by the Horner datapath.
package dds_poly_pkg;

  localparam int DDS_ADDR_WIDTH = 5;
  localparam int DDS_DATA_WIDTH = 32;
  localparam int DDS_FRAC_WIDTH = 27;

  localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_MUL2  = 3'd2,
    ST_MUL1  = 3'd3,
    ST_DONE  = 3'd4
  } dds_state_t;

endpackage : dds_poly_pkg

// File: rtl/dds_horner_mac.sv
// One Horner step: sat(((c * x) >>> FRAC_WIDTH) + b), x is an unsigned fraction.
// Purely combinational; the caller registers the result.
module dds_horner_mac
  import dds_poly_pkg::*;
#(
  parameter int DATA_WIDTH = DDS_DATA_WIDTH,
  parameter int FRAC_WIDTH = DDS_FRAC_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] c,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [FRAC_WIDTH-1:0] x,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int PW = DATA_WIDTH + FRAC_WIDTH + 1;

  logic signed [PW-1:0]           prod;
  logic signed [PW-1:0]           shifted;
  logic signed [PW-1:0]           sum_wide;
  logic        [PW-DATA_WIDTH:0]  upper;
  logic                           ovf;

  always_comb begin
    // x is zero-extended so a full-scale fraction never flips the product sign
    prod     = $signed(c) * $signed({1'b0, x});
    shifted  = prod >>> FRAC_WIDTH;
    sum_wide = shifted + PW'($signed(b));
    // In range only if every bit from the result sign upward agrees
    upper    = sum_wide[PW-1:DATA_WIDTH-1];
    ovf      = !((&upper) || (~|upper));
    if (ovf) begin
      result = sum_wide[PW-1] ? DATA_WIDTH'(SAT_MIN) : DATA_WIDTH'(SAT_MAX);
    end else begin
      result = sum_wide[DATA_WIDTH-1:0];
    end
  end

endmodule : dds_horner_mac

// File: rtl/dds_poly_eval.sv
// Second-order polynomial evaluator: ROM fetch followed by two Horner steps
// through a single shared multiply-shift-add-saturate stage.
module dds_poly_eval
  import dds_poly_pkg::*;
#(
  parameter int ADDR_WIDTH = DDS_ADDR_WIDTH,
  parameter int DATA_WIDTH = DDS_DATA_WIDTH,
  parameter int FRAC_WIDTH = DDS_FRAC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           phase,
  output logic                  ready,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] coef_a0,
  input  logic [DATA_WIDTH-1:0] coef_a1,
  input  logic [DATA_WIDTH-1:0] coef_a2,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  y_valid
);

  dds_state_t            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg,  addr_next;
  logic [FRAC_WIDTH-1:0] frac_reg,  frac_next;
  logic [DATA_WIDTH-1:0] acc_reg,   acc_next;
  logic [DATA_WIDTH-1:0] y_reg,     y_next;

  logic [DATA_WIDTH-1:0] mac_c;
  logic [DATA_WIDTH-1:0] mac_b;
  logic [DATA_WIDTH-1:0] mac_result;

  // First step folds A2 into A1; second step folds the accumulator into A0
  always_comb begin
    if (state_reg == ST_MUL2) begin
      mac_c = coef_a2;
      mac_b = coef_a1;
    end else begin
      mac_c = acc_reg;
      mac_b = coef_a0;
    end
  end

  dds_horner_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_mac (
    .c      (mac_c),
    .b      (mac_b),
    .x      (frac_reg),
    .result (mac_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      frac_reg  <= '0;
      acc_reg   <= '0;
      y_reg     <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      frac_reg  <= frac_next;
      acc_reg   <= acc_next;
      y_reg     <= y_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    frac_next  = frac_reg;
    acc_next   = acc_reg;
    y_next     = y_reg;
    ready      = 1'b0;
    rom_en     = 1'b0;
    y_valid    = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          addr_next  = phase[31 -: ADDR_WIDTH];
          frac_next  = phase[FRAC_WIDTH-1:0];
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // ROM data appears on coef_* at the start of the next cycle
        rom_en     = 1'b1;
        state_next = ST_MUL2;
      end
      ST_MUL2: begin
        acc_next   = mac_result;
        state_next = ST_MUL1;
      end
      ST_MUL1: begin
        y_next     = mac_result;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        y_valid    = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign rom_addr = addr_reg;
  assign y        = y_reg;

endmodule : dds_poly_eval

// File: tb/tb_dds_poly_eval.sv
// Directed bench for dds_poly_eval with behavioural coefficient ROMs and
// hand-computed expected samples, checked by immediate assertions.
`timescale 1ns/1ps
module tb_dds_poly_eval;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] phase;
  logic        ready;
  logic        rom_en;
  logic [4:0]  rom_addr;
  logic [31:0] coef_a0, coef_a1, coef_a2;
  logic [31:0] y;
  logic        y_valid;

  logic [31:0] a0_mem [32];
  logic [31:0] a1_mem [32];
  logic [31:0] a2_mem [32];

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  int vsnap;

  dds_poly_eval dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .phase    (phase),
    .ready    (ready),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .coef_a0  (coef_a0),
    .coef_a1  (coef_a1),
    .coef_a2  (coef_a2),
    .y        (y),
    .y_valid  (y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read ROMs holding their data while disabled
  initial begin
    coef_a0 = '0;
    coef_a1 = '0;
    coef_a2 = '0;
  end
  always @(posedge clk) begin
    if (rom_en) begin
      coef_a0 <= a0_mem[rom_addr];
      coef_a1 <= a1_mem[rom_addr];
      coef_a2 <= a2_mem[rom_addr];
    end
  end

  always @(negedge clk) begin
    if (y_valid === 1'b1) vcount++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_coef(input int a, input logic [31:0] c2, input logic [31:0] c1,
                          input logic [31:0] c0);
    a2_mem[a] = c2;
    a1_mem[a] = c1;
    a0_mem[a] = c0;
  endtask

  // Full request from IDLE, checking every cycle T..T+5
  task automatic do_op(input string tag, input logic [31:0] ph, input logic [4:0] exp_addr,
                       input logic [31:0] exp_acc, input logic [31:0] exp_y);
    chk({tag, "_ready_T"}, {31'd0, ready}, 32'd1);
    start = 1'b1;
    phase = ph;
    tick();                                   // T+1 FETCH
    start = 1'b0;
    chk({tag, "_rom_en_T1"}, {31'd0, rom_en}, 32'd1);
    chk({tag, "_addr_T1"}, {27'd0, rom_addr}, {27'd0, exp_addr});
    chk({tag, "_ready_T1"}, {31'd0, ready}, 32'd0);
    tick();                                   // T+2 MUL2
    chk({tag, "_rom_en_T2"}, {31'd0, rom_en}, 32'd0);
    tick();                                   // T+3 MUL1
    chk({tag, "_acc_T3"}, dut.acc_reg, exp_acc);
    chk({tag, "_valid_T3"}, {31'd0, y_valid}, 32'd0);
    tick();                                   // T+4 DONE
    chk({tag, "_valid_T4"}, {31'd0, y_valid}, 32'd1);
    chk({tag, "_y_T4"}, y, exp_y);
    tick();                                   // T+5 IDLE
    chk({tag, "_valid_T5"}, {31'd0, y_valid}, 32'd0);
    chk({tag, "_ready_T5"}, {31'd0, ready}, 32'd1);
    chk({tag, "_y_hold"}, y, exp_y);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) set_coef(i, 32'h0, 32'h0, 32'h0);
    rst_n = 1'b0;
    start = 1'b0;
    phase = 32'h0;
    tick();
    tick();
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_rom_en", {31'd0, rom_en}, 32'd0);
    chk("rst_addr", {27'd0, rom_addr}, 32'd0);
    chk("rst_y", y, 32'd0);
    chk("rst_valid", {31'd0, y_valid}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 0x10000000 + 0.5 * 0x40000000
    set_coef(0, 32'h0, 32'h4000_0000, 32'h1000_0000);
    do_op("basic", 32'h0400_0000, 5'd0, 32'h4000_0000, 32'h3000_0000);

    // -1 * 0.5 floors to -1
    set_coef(0, 32'h0, 32'hFFFF_FFFF, 32'h0);
    do_op("negfloor", 32'h0400_0000, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // acc clamps; second step then gives 0x7FFFFFFF*x>>>27 = 0x7FFFFFEF
    set_coef(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0);
    do_op("sat", 32'h07FF_FFFF, 5'd0, 32'h7FFF_FFFF, 32'h7FFF_FFEF);

    // Negative clamp: -2^31 * ~1 + -2^31 saturates at both steps
    set_coef(0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    do_op("negsat", 32'h07FF_FFFF, 5'd0, 32'h8000_0000, 32'h8000_0000);

    // Handshake: a start at T+2 with a different phase must be ignored
    set_coef(31, 32'h0, 32'h4000_0000, 32'h1234_5678);
    vsnap = vcount;
    chk("hs_ready_T", {31'd0, ready}, 32'd1);
    start = 1'b1;
    phase = 32'hF800_0000;
    tick();                                   // T+1
    start = 1'b0;
    chk("hs_rom_en_T1", {31'd0, rom_en}, 32'd1);
    chk("hs_addr_T1", {27'd0, rom_addr}, 32'd31);
    tick();                                   // T+2
    chk("hs_rom_en_T2", {31'd0, rom_en}, 32'd0);
    start = 1'b1;
    phase = 32'h07FF_FFFF;
    tick();                                   // T+3
    start = 1'b0;
    chk("hs_addr_T3", {27'd0, rom_addr}, 32'd31);
    tick();                                   // T+4
    chk("hs_y_T4", y, 32'h1234_5678);
    tick();                                   // T+5
    chk("hs_single_valid", vcount - vsnap, 32'd1);
    chk("hs_rom_en_T5", {31'd0, rom_en}, 32'd0);
    do_op("hs_next", 32'hF800_0000, 5'd31, 32'h4000_0000, 32'h1234_5678);

    // Reset asserted while in MUL2
    set_coef(0, 32'h0, 32'h4000_0000, 32'h1000_0000);
    vsnap = vcount;
    start = 1'b1;
    phase = 32'h0400_0000;
    tick();                                   // FETCH
    start = 1'b0;
    tick();                                   // MUL2
    rst_n = 1'b0;
    tick();
    chk("rmid_ready", {31'd0, ready}, 32'd1);
    chk("rmid_y", y, 32'd0);
    chk("rmid_valid", {31'd0, y_valid}, 32'd0);
    chk("rmid_addr", {27'd0, rom_addr}, 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("rmid_no_valid", vcount - vsnap, 32'd0);
    chk("rmid_idle", {31'd0, ready}, 32'd1);
    do_op("after_rst", 32'h0400_0000, 5'd0, 32'h4000_0000, 32'h3000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dds_poly_eval
